// File: rtl/serial_byte_adder_ctrl_pkg.sv
// Shared types and constants for the serial byte adder sequencer.
// Imported by the interface, the controller and the byte datapath.
package serial_adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_byte_adder_ctrl_if.sv
// Request/response bundle between a requester and the serial adder.
// Master drives operands and result acceptance; slave is the adder.
interface serial_byte_adder_ctrl_if #(
  parameter int NBYTES = 4
);
  import serial_adder_pkg::*;

  localparam int W = BYTE_W * NBYTES;

  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         CIN;
  logic         SUB;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] SUM;
  logic         COUT;
  logic         BUSY;

  modport master (
    output IN_VALID, A, B, CIN, SUB, OUT_READY,
    input  IN_READY, OUT_VALID, SUM, COUT, BUSY
  );

  modport slave (
    input  IN_VALID, A, B, CIN, SUB, OUT_READY,
    output IN_READY, OUT_VALID, SUM, COUT, BUSY
  );

endinterface

// File: rtl/serial_byte_adder_ctrl_adder.sv
// The shared 8-bit ripple adder reused one byte per cycle.
// Purely combinational; the caller owns any carry storage.
module full_adder_eight_bit
  import serial_adder_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] s,
  output logic              cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};

endmodule

// File: rtl/serial_byte_adder_ctrl.sv
// Wide add/subtract sequenced LSB-first over one byte adder.
// Carry crosses bytes only through the carry register.
module serial_byte_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input logic               CLK,
  input logic               RST,
  serial_byte_adder_ctrl_if.slave bus
);

  localparam int W  = BYTE_W * NBYTES;
  localparam int IW = idx_w(NBYTES);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  if (NBYTES < 1 || NBYTES > 16) begin : g_bad_nbytes
    $error("serial_byte_adder_ctrl: NBYTES must be 1..16");
  end

  logic [1:0]        state;
  logic [W-1:0]      areg;
  logic [W-1:0]      breg;
  logic [W-1:0]      sum;
  logic              carry;
  logic              cout;
  logic [IW-1:0]     idx;
  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;
  logic [BYTE_W-1:0] s_byte;
  logic              c_byte;
  logic              last;

  assign a_byte = areg[BYTE_W*int'(idx) +: BYTE_W];
  assign b_byte = breg[BYTE_W*int'(idx) +: BYTE_W];
  assign last   = (idx == IW'(NBYTES - 1));

  full_adder_eight_bit u_fa (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry),
    .s    (s_byte),
    .cout (c_byte)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      areg  <= '0;
      breg  <= '0;
      sum   <= '0;
      carry <= 1'b0;
      cout  <= 1'b0;
      idx   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.IN_VALID) begin
            areg  <= bus.A;
            // subtract is A + ~B + 1
            breg  <= bus.SUB ? ~bus.B : bus.B;
            carry <= bus.SUB | bus.CIN;
            idx   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sum[BYTE_W*int'(idx) +: BYTE_W] <= s_byte;
          carry <= c_byte;
          idx   <= last ? '0 : idx + IW'(1);
          if (last) begin
            cout  <= c_byte;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.OUT_READY) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.IN_READY  = (state == S_IDLE);
  assign bus.OUT_VALID = (state == S_DONE);
  assign bus.BUSY      = (state != S_IDLE);
  assign bus.SUM       = sum;
  assign bus.COUT      = cout;

endmodule

// File: tb/tb_serial_byte_adder_ctrl.sv
// Scoreboard bench for the serial byte adder, 4-byte and 1-byte builds.
// Expected results are queued at accept and checked at output handshake.
module tb_serial_byte_adder_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_byte_adder_ctrl_if #(.NBYTES(4)) b4 ();
  serial_byte_adder_ctrl_if #(.NBYTES(1)) b1 ();

  serial_byte_adder_ctrl #(.NBYTES(4)) u4 (
    .CLK (clk),
    .RST (rst),
    .bus (b4.slave)
  );

  serial_byte_adder_ctrl #(.NBYTES(1)) u1 (
    .CLK (clk),
    .RST (rst),
    .bus (b1.slave)
  );

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    int          t;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  logic pv4 = 1'b0;
  logic pv1 = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model4(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic cin,
                                          input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + 33'd1;
    return {1'b0, a} + {1'b0, b} + {32'd0, cin};
  endfunction

  function automatic logic [8:0] model1(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic cin,
                                         input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + 9'd1;
    return {1'b0, a} + {1'b0, b} + {8'd0, cin};
  endfunction

  // monitors look 1 time unit after the falling edge, after drivers settle
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (b4.OUT_VALID && !pv4) begin
      if (q4.size() == 0) chk("stale4", 1, 0);
      else chk("lat4", 64'(cyc - q4[0].t), 4);
    end
    if (b4.OUT_VALID && b4.OUT_READY && q4.size() > 0) begin
      e = q4.pop_front();
      chk("sum4", 64'(b4.SUM), 64'(e.sum));
      chk("cout4", 64'(b4.COUT), 64'(e.cout));
    end
    pv4 <= b4.OUT_VALID;
  end

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (b1.OUT_VALID && !pv1) begin
      if (q1.size() == 0) chk("stale1", 1, 0);
      else chk("lat1", 64'(cyc - q1[0].t), 1);
    end
    if (b1.OUT_VALID && b1.OUT_READY && q1.size() > 0) begin
      e = q1.pop_front();
      chk("sum1", 64'(b1.SUM), 64'(e.sum));
      chk("cout1", 64'(b1.COUT), 64'(e.cout));
    end
    pv1 <= b1.OUT_VALID;
  end

  task automatic go4(input logic [31:0] a, input logic [31:0] b,
                     input logic cin, input logic sub);
    logic [32:0] r;
    exp_t        e;
    int          k;
    @(negedge clk);
    b4.A = a; b4.B = b; b4.CIN = cin; b4.SUB = sub;
    b4.IN_VALID = 1'b1;
    k = 0;
    while (!b4.IN_READY && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      chk("accept4_timeout", 0, 1);
    end else begin
      r = model4(a, b, cin, sub);
      e.sum = r[31:0]; e.cout = r[32]; e.t = cyc + 1;
      q4.push_back(e);
    end
    @(negedge clk);
    b4.IN_VALID = 1'b0;
  endtask

  task automatic go1(input logic [7:0] a, input logic [7:0] b,
                     input logic cin, input logic sub);
    logic [8:0] r;
    exp_t       e;
    int         k;
    @(negedge clk);
    b1.A = a; b1.B = b; b1.CIN = cin; b1.SUB = sub;
    b1.IN_VALID = 1'b1;
    k = 0;
    while (!b1.IN_READY && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      chk("accept1_timeout", 0, 1);
    end else begin
      r = model1(a, b, cin, sub);
      e.sum = {24'd0, r[7:0]}; e.cout = r[8]; e.t = cyc + 1;
      q1.push_back(e);
    end
    @(negedge clk);
    b1.IN_VALID = 1'b0;
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while ((q4.size() != 0 || q1.size() != 0 ||
            !b4.IN_READY || !b1.IN_READY) && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (k >= limit) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int last;
    int k;
    logic [32:0] r;
    exp_t e;

    rst = 1'b1;
    b4.IN_VALID = 0; b4.A = '0; b4.B = '0; b4.CIN = 0; b4.SUB = 0;
    b4.OUT_READY = 1;
    b1.IN_VALID = 0; b1.A = '0; b1.B = '0; b1.CIN = 0; b1.SUB = 0;
    b1.OUT_READY = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 64'(b4.IN_READY), 1);
    chk("rst_out_valid", 64'(b4.OUT_VALID), 0);
    chk("rst_busy", 64'(b4.BUSY), 0);
    chk("rst_sum", 64'(b4.SUM), 0);
    chk("rst_cout", 64'(b4.COUT), 0);
    chk("rst1_in_ready", 64'(b1.IN_READY), 1);

    go4(32'h0000_00FF, 32'h0000_0001, 0, 0);
    go4(32'hFFFF_FFFF, 32'h0000_0001, 0, 0);
    go4(32'h1234_5678, 32'h1111_1111, 1, 0);
    go4(32'h0000_0005, 32'h0000_0007, 1, 1);
    go4(32'h0000_0007, 32'h0000_0005, 1, 1);
    go4(32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1);
    drain(100);

    // backpressure in DONE with IN_VALID toggling
    b4.OUT_READY = 1'b0;
    r = model4(32'h8000_00F0, 32'h8000_0020, 1, 0);
    go4(32'h8000_00F0, 32'h8000_0020, 1, 0);
    k = 0;
    while (!b4.OUT_VALID && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) chk("bp_done_timeout", 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b4.IN_VALID = ~b4.IN_VALID;
      b4.A = 32'h1111_0000 + 32'(i);
      chk("bp_valid", 64'(b4.OUT_VALID), 1);
      chk("bp_in_ready", 64'(b4.IN_READY), 0);
      chk("bp_sum", 64'(b4.SUM), 64'(r[31:0]));
      chk("bp_cout", 64'(b4.COUT), 64'(r[32]));
    end
    @(negedge clk);
    b4.IN_VALID = 1'b0;
    b4.OUT_READY = 1'b1;
    @(negedge clk);
    chk("bp_idle_in_ready", 64'(b4.IN_READY), 1);
    chk("bp_idle_out_valid", 64'(b4.OUT_VALID), 0);
    chk("bp_queue_empty", 64'(q4.size()), 0);

    // reset during the second RUN cycle
    go4(32'h0000_0010, 32'h0000_0020, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    q4.delete();
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_in_ready", 64'(b4.IN_READY), 1);
    chk("mrst_out_valid", 64'(b4.OUT_VALID), 0);
    chk("mrst_busy", 64'(b4.BUSY), 0);
    chk("mrst_sum", 64'(b4.SUM), 0);
    chk("mrst_cout", 64'(b4.COUT), 0);
    repeat (8) @(negedge clk);
    go4(32'd3, 32'd4, 0, 0);
    drain(100);

    // one-byte build
    go1(8'hFF, 8'h01, 0, 0);
    go1(8'h05, 8'h07, 1, 1);
    drain(100);

    // back-to-back with IN_VALID held high
    @(negedge clk);
    b1.IN_VALID = 1'b1;
    last = 0;
    for (int i = 0; i < 4; i++) begin
      b1.A = 8'(8'h30 + 8'(i * 17));
      b1.B = 8'(8'h0F + 8'(i * 3));
      b1.CIN = i[0];
      b1.SUB = i[1];
      k = 0;
      while (!b1.IN_READY && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (k >= 20) begin
        chk("b2b_timeout", 0, 1);
      end else begin
        r = {24'd0, model1(b1.A, b1.B, b1.CIN, b1.SUB)};
        e.sum = {24'd0, r[7:0]}; e.cout = r[8]; e.t = cyc + 1;
        q1.push_back(e);
        if (i > 0) chk("b2b_interval", 64'(cyc + 1 - last), 3);
        last = cyc + 1;
      end
      @(negedge clk);
    end
    b1.IN_VALID = 1'b0;
    drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_byte_adder_ctrl.md
Name: serial_byte_adder_ctrl

Overview:
Sequencer that performs NBYTES-wide add/subtract by time-multiplexing one 8-bit ripple adder, one byte per cycle, least significant byte first. The carry is held in a register between byte steps. Operands enter through a valid/ready handshake and results leave through one. It sits between a requester (register file / ALU front-end) and the team's shared byte adder, and lets wide arithmetic reuse the narrow datapath.

Parameters:
NBYTES, 4, operand width in bytes (legal range 1..16; NBYTES<1 must raise an elaboration error)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous reset, active-high
IN_VALID  in  1  requester presents an operation
IN_READY  out  1  block can accept an operation (high only in IDLE)
A  in  8*NBYTES  operand A
B  in  8*NBYTES  operand B
CIN  in  1  carry-in for add (ignored when SUB=1)
SUB  in  1  0 = A+B+CIN, 1 = A-B (A + ~B + 1)
OUT_VALID  out  1  SUM/COUT hold a completed result
OUT_READY  in  1  consumer accepts the result
SUM  out  8*NBYTES  result
COUT  out  1  final carry; for SUB it is the no-borrow flag (1 when A>=B unsigned)
BUSY  out  1  high in RUN and DONE

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RST. All outputs are registered or decoded from state.
- Reset values (visible the cycle after RST is sampled high): state IDLE, IN_READY=1, OUT_VALID=0, BUSY=0, SUM=0, COUT=0, carry reg=0, byte index=0.
- RST has priority over every other event, including mid-RUN and in DONE. The operation in flight is discarded and no OUT_VALID is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE: IN_READY=1. When IN_VALID&&IN_READY at an edge:
  - latch A into the A register;
  - latch B, or ~B when SUB=1, into the B register;
  - set carry reg = SUB ? 1 : CIN;
  - set index=0 and go to RUN.
  - When IN_VALID=0, stay in IDLE.
- RUN: the adder is driven with byte[index] of each register plus the carry reg. Each edge:
  - write adder sum into SUM byte[index];
  - load adder carry-out into carry reg;
  - increment index.
  - On the edge where index==NBYTES-1, also load COUT from the adder carry-out and go to DONE.
  - IN_VALID is ignored and IN_READY=0.
- Latency: handshake at edge t0 gives OUT_VALID=1 after edge t0+NBYTES (exactly NBYTES RUN cycles). NBYTES=1 means one RUN cycle.
- DONE: OUT_VALID=1. SUM and COUT are stable until the OUT_VALID&&OUT_READY edge, then the block returns to IDLE.
  - No same-cycle bypass: IN_READY rises the cycle after the output handshake.
  - Minimum issue interval is NBYTES+2 cycles.
- SUM upper bytes are partially updated during RUN, so SUM is meaningful only while OUT_VALID=1.
- Arithmetic is unsigned modulo 2^(8*NBYTES). The carry propagates only through the carry reg; there is no combinational path across bytes.
- Index width is clog2(NBYTES) with a minimum of 1. Index wrap is never reached because the exit happens at NBYTES-1.

Decomposition:
- Package serial_adder_pkg holds:
  - state enum typedef {IDLE, RUN, DONE};
  - constant BYTE_W=8;
  - helper function for index width.
- Exactly one sub-module: the team's existing full_adder_eight_bit, instantiated once as the byte datapath.
- The controller holds only registers, FSM and byte muxing.

Test Plan:
1. NBYTES=4, A=0x000000FF, B=0x00000001, CIN=0, SUB=0 -> SUM=0x00000100, COUT=0, OUT_VALID exactly 4 cycles after accept.
2. A=0xFFFFFFFF, B=0x00000001, CIN=0 -> SUM=0x00000000, COUT=1 (carry ripples through all bytes). A=0x12345678, B=0x11111111, CIN=1 -> SUM=0x2345678A, COUT=0.
3. SUB=1 with CIN=1 (must be ignored):
   - A=0x00000005, B=0x00000007 -> SUM=0xFFFFFFFE, COUT=0;
   - A=7, B=5 -> SUM=0x00000002, COUT=1.
4. Backpressure: hold OUT_READY=0 for 5 cycles in DONE while toggling IN_VALID -> SUM/COUT/OUT_VALID stable, IN_READY=0, no new accept. Then raise OUT_READY -> IDLE, with IN_READY=1 the next cycle.
5. Reset mid-RUN: assert RST for one cycle during the 2nd RUN cycle -> next cycle IN_READY=1, OUT_VALID=0, BUSY=0, SUM=0, COUT=0, and no stale result ever appears. A following op A=3, B=4 gives SUM=7.
6. NBYTES=1 build: A=0xFF, B=0x01 -> SUM=0x00, COUT=1, OUT_VALID 1 cycle after accept. Back-to-back requests with IN_VALID held high -> issue interval of 3 cycles.
